// File: rtl/riv_retry_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : riv_retry_timer_if
// Description : Bundle of handshake and counter-control signals between a
//               retry timer (slave side) and the logic that requests timed
//               attempts and owns the external down-counter (master side).
//   start         request to begin a timed attempt sequence
//   ack           far-end response ending the sequence successfully
//   timeout_value timeout in clk cycles, sampled on accepted start
//   cnt_load      load strobe to the down-counter
//   cnt_value     value to load into the down-counter
//   cnt_enable    decrement enable to the down-counter
//   cnt_done      counter-is-zero flag from the down-counter
//   busy          sequence in progress
//   retry         one-cycle pulse on a timeout followed by a retry
//   success       one-cycle pulse when ack ends the sequence
//   fail          one-cycle pulse when the final attempt times out
//   retry_count   retries issued in the current or most recent sequence
// Revision    : 1.0 - initial release
// ============================================================================
interface riv_retry_timer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ack;
  logic [WIDTH-1:0] timeout_value;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_enable;
  logic             cnt_done;
  logic             busy;
  logic             retry;
  logic             success;
  logic             fail;
  logic [3:0]       retry_count;

  modport master (
    output start, ack, timeout_value, cnt_done,
    input  cnt_load, cnt_value, cnt_enable, busy, retry, success, fail,
           retry_count
  );

  modport slave (
    input  start, ack, timeout_value, cnt_done,
    output cnt_load, cnt_value, cnt_enable, busy, retry, success, fail,
           retry_count
  );
endinterface
`default_nettype wire

// File: rtl/riv_retry_timer.sv
`default_nettype none
// ============================================================================
// Module      : riv_retry_timer
// Description : Timed attempt sequencer. On start it loads an external
//               down-counter, waits for ack or counter expiry, and retries up
//               to MAX_RETRY times before reporting fail.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - riv_retry_timer_if.slave (handshake + counter ctrl)
// Parameters  : WIDTH     - timeout / counter width in bits
//               MAX_RETRY - retries after the first attempt (0..15)
// Options     : RIV_RETRY_TIMER_BACKOFF_EN - when defined, attempt n loads
//               timeout << n, saturated to all ones on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module riv_retry_timer #(
  parameter int WIDTH     = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  riv_retry_timer_if.slave   bus
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] timeout_cap;
  logic             load_strobe;
  logic [WIDTH-1:0] load_value;
  logic             busy_flag;
  logic             retry_pulse;
  logic             success_pulse;
  logic             fail_pulse;
  logic [3:0]       count;

  logic [3:0]       next_count;
  logic [WIDTH-1:0] retry_value;

  assign next_count = count + 4'd1;

`ifdef RIV_RETRY_TIMER_BACKOFF_EN
  // Shift in a widened vector so any bit pushed past the top is detectable.
  function automatic logic [WIDTH-1:0] sat_shift(input logic [WIDTH-1:0] base,
                                                 input logic [3:0]       n);
    logic [WIDTH+14:0] wide;
    wide = {15'b0, base} << n;
    if (|wide[WIDTH+14:WIDTH]) return '1;
    return wide[WIDTH-1:0];
  endfunction

  assign retry_value = sat_shift(timeout_cap, next_count);
`else
  assign retry_value = timeout_cap;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      timeout_cap   <= '0;
      load_strobe   <= 1'b0;
      load_value    <= '0;
      busy_flag     <= 1'b0;
      retry_pulse   <= 1'b0;
      success_pulse <= 1'b0;
      fail_pulse    <= 1'b0;
      count         <= 4'd0;
    end else begin
      load_strobe   <= 1'b0;
      retry_pulse   <= 1'b0;
      success_pulse <= 1'b0;
      fail_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // First attempt uses the unshifted timeout in both build modes.
            timeout_cap <= bus.timeout_value;
            load_value  <= bus.timeout_value;
            load_strobe <= 1'b1;
            count       <= 4'd0;
            busy_flag   <= 1'b1;
            state       <= ARM;
          end
        end
        ARM: begin
          state <= WAIT;
        end
        WAIT: begin
          // ack wins over a simultaneous expiry.
          if (bus.ack) begin
            success_pulse <= 1'b1;
            busy_flag     <= 1'b0;
            state         <= IDLE;
          end else if (bus.cnt_done) begin
            if (count < MAX_CNT) begin
              retry_pulse <= 1'b1;
              count       <= next_count;
              load_value  <= retry_value;
              load_strobe <= 1'b1;
              state       <= ARM;
            end else begin
              fail_pulse <= 1'b1;
              busy_flag  <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          busy_flag <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the counter stops on the very cycle it reports zero.
  assign bus.cnt_enable  = (state == WAIT) && !bus.cnt_done && !bus.ack;
  assign bus.cnt_load    = load_strobe;
  assign bus.cnt_value   = load_value;
  assign bus.busy        = busy_flag;
  assign bus.retry       = retry_pulse;
  assign bus.success     = success_pulse;
  assign bus.fail        = fail_pulse;
  assign bus.retry_count = count;

endmodule
`default_nettype wire

// File: tb/tb_riv_retry_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riv_retry_timer
// Description : Self-checking bench for riv_retry_timer. A vector table
//               drives cnt_done directly; directed sequences use a small
//               down-counter model in place of the external counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riv_retry_timer;

  localparam int WIDTH     = 16;
  localparam int MAX_RETRY = 3;

  typedef struct packed {
    logic        rst_n;
    logic        start;
    logic        ack;
    logic        done;
    logic [15:0] tv;
    logic        load;
    logic [15:0] val;
    logic        en;
    logic        busy;
    logic        retry;
    logic        succ;
    logic        fail;
    logic [3:0]  rc;
  } vec_t;

  vec_t vecs[$];

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        ack       = 1'b0;
  logic        done_tv   = 1'b0;
  logic        use_model = 1'b0;
  logic [15:0] tv        = 16'd0;
  logic [15:0] cnt       = 16'd0;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  riv_retry_timer_if #(.WIDTH(WIDTH)) bus ();

  assign bus.start         = start;
  assign bus.ack           = ack;
  assign bus.timeout_value = tv;
  assign bus.cnt_done      = use_model ? (cnt == 16'd0) : done_tv;

  riv_retry_timer #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model of the external down-counter.
  always @(posedge clk) begin
    if (bus.cnt_load)        cnt <= bus.cnt_value;
    else if (bus.cnt_enable) cnt <= cnt - 16'd1;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic row(input logic r, input logic s, input logic a,
                     input logic d, input logic [15:0] t,
                     input logic ld, input logic [15:0] v, input logic e,
                     input logic b, input logic rt, input logic sc,
                     input logic f, input logic [3:0] c);
    vec_t x;
    x = '{rst_n:r, start:s, ack:a, done:d, tv:t, load:ld, val:v, en:e,
          busy:b, retry:rt, succ:sc, fail:f, rc:c};
    vecs.push_back(x);
  endtask

  function automatic logic [31:0] outs();
    return {6'd0, bus.cnt_load, bus.cnt_value, bus.cnt_enable, bus.busy,
            bus.retry, bus.success, bus.fail, bus.retry_count};
  endfunction

  initial begin
    logic [15:0] lv[4];
    logic [15:0] exp_lv[4];
    int          nloads, nretry, waits, nfail, nsucc, overlap, pulses;
    logic        hit;
    logic [3:0]  rc_at_end;

    //   rst st ack done tv       load val      en busy rt sc fl rc
    row(0, 0, 0, 0, 16'd0,    0, 16'd0, 0, 0, 0, 0, 0, 4'd0);  // reset state
    row(1, 1, 0, 1, 16'd5,    0, 16'd0, 0, 0, 0, 0, 0, 4'd0);  // start accepted
    row(1, 0, 1, 0, 16'd0,    1, 16'd5, 0, 1, 0, 0, 0, 4'd0);  // ARM, ack ignored
    row(1, 0, 0, 0, 16'd0,    0, 16'd5, 1, 1, 0, 0, 0, 4'd0);  // WAIT counting
    row(1, 1, 0, 0, 16'd7,    0, 16'd5, 1, 1, 0, 0, 0, 4'd0);  // start ignored
    row(1, 0, 1, 1, 16'd0,    0, 16'd5, 0, 1, 0, 0, 0, 4'd0);  // ack+done
    row(1, 0, 0, 0, 16'd0,    0, 16'd5, 0, 0, 0, 1, 0, 4'd0);  // success only
    row(1, 0, 1, 0, 16'd0,    0, 16'd5, 0, 0, 0, 0, 0, 4'd0);  // ack in IDLE
    row(1, 1, 0, 1, 16'd0,    0, 16'd5, 0, 0, 0, 0, 0, 4'd0);  // start, tv=0
    row(1, 0, 0, 1, 16'd0,    1, 16'd0, 0, 1, 0, 0, 0, 4'd0);  // ARM 0
    row(1, 0, 0, 1, 16'd0,    0, 16'd0, 0, 1, 0, 0, 0, 4'd0);  // WAIT expires
    row(1, 0, 0, 1, 16'd0,    1, 16'd0, 0, 1, 1, 0, 0, 4'd1);  // retry 1
    row(1, 0, 0, 1, 16'd0,    0, 16'd0, 0, 1, 0, 0, 0, 4'd1);
    row(1, 0, 0, 1, 16'd0,    1, 16'd0, 0, 1, 1, 0, 0, 4'd2);  // retry 2
    row(1, 0, 0, 1, 16'd0,    0, 16'd0, 0, 1, 0, 0, 0, 4'd2);
    row(1, 0, 0, 1, 16'd0,    1, 16'd0, 0, 1, 1, 0, 0, 4'd3);  // retry 3
    row(1, 0, 0, 1, 16'd0,    0, 16'd0, 0, 1, 0, 0, 0, 4'd3);  // final expiry
    row(1, 0, 0, 0, 16'd0,    0, 16'd0, 0, 0, 0, 0, 1, 4'd3);  // fail pulse
    row(1, 0, 0, 0, 16'd0,    0, 16'd0, 0, 0, 0, 0, 0, 4'd3);  // count held
    row(1, 1, 0, 0, 16'd9,    0, 16'd0, 0, 0, 0, 0, 0, 4'd3);  // new start
    row(1, 0, 0, 0, 16'd0,    1, 16'd9, 0, 1, 0, 0, 0, 4'd0);  // count cleared
    row(1, 0, 0, 0, 16'd0,    0, 16'd9, 1, 1, 0, 0, 0, 4'd0);
    row(0, 0, 0, 0, 16'd0,    0, 16'd9, 1, 1, 0, 0, 0, 4'd0);  // reset in WAIT
    row(1, 0, 0, 0, 16'd0,    0, 16'd0, 0, 0, 0, 0, 0, 4'd0);  // all cleared
    row(1, 1, 0, 0, 16'd3,    0, 16'd0, 0, 0, 0, 0, 0, 4'd0);
    row(1, 0, 0, 0, 16'd0,    1, 16'd3, 0, 1, 0, 0, 0, 4'd0);
    row(1, 0, 1, 0, 16'd0,    0, 16'd3, 0, 1, 0, 0, 0, 4'd0);  // ack stops en
    row(1, 0, 0, 0, 16'd0,    0, 16'd3, 0, 0, 0, 1, 0, 4'd0);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      start   = vecs[i].start;
      ack     = vecs[i].ack;
      done_tv = vecs[i].done;
      tv      = vecs[i].tv;
      #1;
      check($sformatf("vec%0d", i), outs(),
            {6'd0, vecs[i].load, vecs[i].val, vecs[i].en, vecs[i].busy,
             vecs[i].retry, vecs[i].succ, vecs[i].fail, vecs[i].rc});
    end

    // ---- timeout 4, no ack: three retries then fail ----
    @(negedge clk);
    start = 0; ack = 0; use_model = 1'b1;
    repeat (2) @(negedge clk);
`ifdef RIV_RETRY_TIMER_BACKOFF_EN
    exp_lv = '{16'd4, 16'd8, 16'd16, 16'd32};
`else
    exp_lv = '{16'd4, 16'd4, 16'd4, 16'd4};
`endif
    lv = '{default: 16'd0};
    nloads = 0; nretry = 0; nfail = 0; overlap = 0; rc_at_end = 4'd0;
    tv = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && nfail == 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.cnt_load) begin
        if (nloads < 4) lv[nloads] = bus.cnt_value;
        nloads++;
      end
      if (bus.cnt_load && bus.cnt_enable) overlap++;
      if (bus.retry) nretry++;
      if (bus.fail) begin nfail++; rc_at_end = bus.retry_count; end
    end
    check("noack_fail", 32'(nfail), 32'd1);
    check("noack_loads", 32'(nloads), 32'd4);
    check("noack_retries", 32'(nretry), 32'd3);
    check("noack_rc", 32'(rc_at_end), 32'd3);
    check("noack_overlap", 32'(overlap), 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("noack_load%0d", k), 32'(lv[k]), 32'(exp_lv[k]));

    // ---- timeout 5, ack on third WAIT cycle ----
    @(negedge clk);
    nloads = 0; nretry = 0; nsucc = 0; waits = 0; rc_at_end = 4'hF;
    lv[0] = 16'd0;
    tv = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && nsucc == 0; c++) begin
      if (c > 0) begin @(negedge clk); ack = 1'b0; end
      #1;
      if (bus.cnt_load) begin lv[0] = bus.cnt_value; nloads++; end
      if (bus.retry) nretry++;
      if (bus.success) begin nsucc++; rc_at_end = bus.retry_count; end
      if (bus.busy && !bus.cnt_load) begin
        waits++;
        if (waits == 3) begin
          ack = 1'b1;
          #1;
          check("ack_en_low", 32'(bus.cnt_enable), 32'd0);
        end
      end
    end
    ack = 1'b0;
    check("ack_success", 32'(nsucc), 32'd1);
    check("ack_loads", 32'(nloads), 32'd1);
    check("ack_load_val", 32'(lv[0]), 32'd5);
    check("ack_rc", 32'(rc_at_end), 32'd0);
    check("ack_no_retry", 32'(nretry), 32'd0);

    // ---- reset in WAIT with count 7 ----
    @(negedge clk);
    hit = 1'b0;
    tv = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.busy && !bus.cnt_load && cnt == 16'd7) begin
        hit = 1'b1;
        rst_n = 1'b0;
      end
    end
    check("rst_reached_7", 32'(hit), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_all_zero", outs(), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.retry || bus.success || bus.fail || bus.busy) pulses++;
    end
    check("rst_no_pulses", 32'(pulses), 32'd0);
    @(negedge clk);
    tv = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("rst_restart", {15'd0, bus.busy, bus.cnt_load, bus.cnt_value},
          {15'd0, 1'b1, 1'b1, 16'd2});

`ifdef RIV_RETRY_TIMER_BACKOFF_EN
    // ---- backoff saturation on first retry ----
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nloads = 0;
    tv = 16'hC000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60000 && nloads < 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.cnt_load) begin lv[nloads] = bus.cnt_value; nloads++; end
    end
    check("sat_loads", 32'(nloads), 32'd2);
    check("sat_value", 32'(lv[1]), 32'h0000FFFF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
